// File: rtl/ms_flop_bank.sv
// Bank of WIDTH edge-modelled master-slave flip-flops with run-time SR/JK/D/T
// mode select. The master stage updates on posedge from slave feedback, and
// the slave copies the master on negedge. Illegal SR inputs (S=R=1) are
// flagged per bit and accumulated in a sticky flag and a saturating counter.
module ms_flop_bank #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SR_POLICY = 0,  // S=R=1 response: 0 hold, 1 set, 2 reset
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     qm,
    output logic [WIDTH-1:0]     qs,
    output logic [WIDTH-1:0]     qs_n,
    output logic [WIDTH-1:0]     illegal,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0]     qm_next;
    logic [WIDTH-1:0]     illegal_next;
    logic                 err_event;
    logic                 err_sticky_next;
    logic [ERR_CNT_W-1:0] err_cnt_next;

    // Master next-state per channel; present state is always the slave output.
    always_comb begin
        qm_next      = qm;
        illegal_next = '0;
        if (en) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                unique case (mode)
                    MODE_SR: begin
                        unique case ({a[i], b[i]})
                            2'b00: qm_next[i] = qs[i];
                            2'b01: qm_next[i] = 1'b0;
                            2'b10: qm_next[i] = 1'b1;
                            2'b11: begin
                                illegal_next[i] = 1'b1;
                                if (SR_POLICY == 1) begin
                                    qm_next[i] = 1'b1;
                                end else if (SR_POLICY == 2) begin
                                    qm_next[i] = 1'b0;
                                end else begin
                                    qm_next[i] = qs[i];
                                end
                            end
                        endcase
                    end
                    MODE_JK: begin
                        unique case ({a[i], b[i]})
                            2'b00: qm_next[i] = qs[i];
                            2'b01: qm_next[i] = 1'b0;
                            2'b10: qm_next[i] = 1'b1;
                            2'b11: qm_next[i] = ~qs[i];
                        endcase
                    end
                    MODE_D:  qm_next[i] = a[i];
                    MODE_T:  qm_next[i] = a[i] ? ~qs[i] : qs[i];
                endcase
            end
        end
    end

    // Error bookkeeping; an event in the same cycle as a clear restarts the count at one.
    always_comb begin
        err_event       = |illegal_next;
        err_sticky_next = err_sticky;
        err_cnt_next    = err_cnt;
        if (err_event) begin
            err_sticky_next = 1'b1;
            if (clr_err) begin
                err_cnt_next = ERR_CNT_W'(1);
            end else if (err_cnt != CNT_MAX) begin
                err_cnt_next = err_cnt + ERR_CNT_W'(1);
            end
        end else if (clr_err) begin
            err_sticky_next = 1'b0;
            err_cnt_next    = '0;
        end
    end

    // Master stage and error state capture on the rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qm         <= '0;
            illegal    <= '0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else begin
            qm         <= qm_next;
            illegal    <= illegal_next;
            err_sticky <= err_sticky_next;
            err_cnt    <= err_cnt_next;
        end
    end

    // Slave stage follows the master on the falling edge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            qs   <= '0;
            qs_n <= '1;
        end else begin
            qs   <= qm;
            qs_n <= ~qm;
        end
    end

endmodule

// File: doc/ms_flop_bank.md
Name: ms_flop_bank

Overview:
WIDTH-bit bank of edge-modelled master-slave flip-flops with run-time selectable SR/JK/D/T mode. The master stage captures on the rising clock edge and the slave copies it on the falling edge. This generalises the single-bit SR master-slave latch and adds:
- a configurable S=R=1 policy
- per-bit illegal-input flags
- a sticky error flag and a saturating error counter

It is used as a storage/teaching primitive in the sequential library.

Parameters:
WIDTH, 8, number of independent flop channels
SR_POLICY, 0, SR-mode response to S=R=1: 0 hold, 1 set-dominant, 2 reset-dominant
ERR_CNT_W, 8, width of error event counter

Ports:
clk  in  1  clock; master edge = posedge, slave edge = negedge
rst  in  1  asynchronous reset, active-high
en  in  1  master capture enable, sampled at posedge
mode  in  2  00 SR, 01 JK, 10 D, 11 T; sampled at posedge
a  in  WIDTH  S / J / D / T input per channel
b  in  WIDTH  R / K input per channel; ignored in D and T modes
clr_err  in  1  synchronous clear of err_sticky/err_cnt, sampled at posedge
qm  out  WIDTH  master stage output
qs  out  WIDTH  slave stage output (flop Q)
qs_n  out  WIDTH  complement of qs
illegal  out  WIDTH  per-bit S=R=1 flag from the last posedge
err_sticky  out  1  set by any illegal event, held until cleared
err_cnt  out  ERR_CNT_W  count of posedges with any illegal bit, saturating

Behaviour:
- Reset (rst=1, asynchronous, both stages):
  - qm=0, qs=0, qs_n=all ones, illegal=0, err_sticky=0, err_cnt=0.
  - Held for as long as rst=1; overrides any edge in progress.
  - Mid-operation assertion clears qs immediately, not at the next negedge.
- Present state for every channel is qs (slave feedback). This eliminates JK/T race-through.
- Posedge with en=1, per bit i (a=a[i], b=b[i], q=qs[i]):
  - SR, ab=00: qm=q.
  - SR, ab=01: qm=0.
  - SR, ab=10: qm=1.
  - SR, ab=11:
    - qm=q if SR_POLICY=0, 1 if 1, 0 if 2.
    - illegal[i]=1.
  - JK: 00 hold q; 01 qm=0; 10 qm=1; 11 qm=~q. illegal[i]=0.
  - D: qm=a. illegal[i]=0.
  - T: qm = a ? ~q : q. illegal[i]=0.
  - SR mode, ab != 11: illegal[i]=0.
- Posedge with en=0: qm holds, illegal=0, no error event.
- Negedge: qs<=qm; qs_n<=~qm. qs_n is always ~qs except during reset, where it is all ones.
- Latency:
  - inputs sampled at posedge N appear on qm immediately after posedge N;
  - they appear on qs half a cycle later, at the following negedge.
  - Exactly one state update per full clock cycle; J=K=1 toggles once per cycle.
- Error path, evaluated at posedge. Let ev = en && mode==SR && any bit with a&b=1.
  - ev=1: err_sticky<=1; err_cnt<=err_cnt+1, saturating at 2^ERR_CNT_W-1 (no wrap).
  - clr_err=1, ev=0: err_sticky<=0, err_cnt<=0.
  - clr_err=1, ev=1: the event wins over the clear, giving err_sticky=1 and err_cnt=1.
  - Multiple illegal bits in one cycle count as one event.
- Mode change takes effect at the next posedge. State is neither reset nor altered by the change itself.
- Inputs a/b/mode/en must be stable around posedge only; their values at negedge are irrelevant.
- The first posedge after rst deassert operates normally. No synchroniser is included; rst deassertion timing is the integrator's responsibility.

Test Plan:
1. Reset: WIDTH=4, rst=1 with a=b=1111 toggling.
   -> qm=qs=0000, qs_n=1111, illegal=0000, err_cnt=0 throughout.
   Deassert rst, then mode=D, a=1010 at posedge.
   -> qm=1010 after posedge; qs=1010 only after the following negedge.
2. SR basics, SR_POLICY=0, mode=SR:
   - ab=(1111,0000) -> qs=1111
   - ab=(0000,0000) -> qs holds 1111
   - ab=(0000,0101) -> qs=1010
   - ab=(0011,0011) -> qs holds 1010, illegal=0011, err_sticky=1, err_cnt=1
3. Policies: with qs=0000, apply S=R=1111.
   -> SR_POLICY=1 gives qs=1111; SR_POLICY=2 gives qs=0000; illegal=1111 in both cases.
4. JK and T toggle: mode=JK, J=K=1111 from qs=0000 for 4 cycles.
   -> qs = 1111, 0000, 1111, 0000; one toggle per cycle, err_cnt unchanged.
   Then mode=T, a=0101 for 2 cycles -> qs = 0101, then 0000.
5. Error counter, ERR_CNT_W=2: 5 consecutive illegal SR cycles.
   -> err_cnt = 1, 2, 3, 3, 3 (saturates).
   - clr_err with no event -> err_cnt=0, err_sticky=0.
   - clr_err together with an illegal event -> err_cnt=1, err_sticky=1.
6. en and reset mid-operation:
   - en=0 with mode=D, a=1111 from qs=0000 -> qm and qs stay 0000.
   - Assert rst while clk is high after qm=1111 was captured -> qm=qs=0000 immediately; qs_n=1111.
